// File: rtl/chip8_mem_pkg.sv
// Shared constants for the Chip-8 work RAM arbiter: bus widths, grant ids
// and FSM state encoding.
package chip8_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  typedef logic [1:0] gnt_t;

  localparam gnt_t GNT_LD  = 2'd0;
  localparam gnt_t GNT_BL  = 2'd1;
  localparam gnt_t GNT_CPU = 2'd2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

endpackage

// File: rtl/chip8_rr_pick2.sv
// Two-way round-robin picker. The last-grant flag lives in the parent so
// it only moves when the parent actually commits a grant.
module chip8_rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  output logic pick_a,
  output logic pick_b
);

  // a wins when alone or when b was served last; b takes everything else
  always_comb begin
    pick_a = req_a && (!req_b || last_b);
    pick_b = req_b && !pick_a;
  end

endmodule

// File: rtl/chip8_ram_arbiter.sv
// Serialises loader, blitter and CPU accesses onto the single-port 4 KiB
// Chip-8 work RAM and drops CPU writes into the interpreter/font area.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a request; ack of the previous access is visible
// ISSUE   | RAM samples ram_addr/ram_wr/ram_in on the closing edge
// CAPTURE | ram_out valid; register rdata and pulse the granted ack
module chip8_ram_arbiter #(
  parameter int                          ADDR_W      = chip8_mem_pkg::ADDR_W,
  parameter int                          DATA_W      = chip8_mem_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]           PROTECT_TOP = 12'h180
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  input  logic              bl_req,
  input  logic [ADDR_W-1:0] bl_addr,
  output logic              bl_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out,
  output logic              protect_err,
  output logic              busy
);

  import chip8_mem_pkg::*;

  logic [1:0] state;
  gnt_t       gnt;
  logic       last_cpu;
  logic       is_wr;
  logic       prot;
  logic       pick_bl;
  logic       pick_cpu;
  logic       cpu_prot_wr;

  chip8_rr_pick2 u_pick (
    .req_a  (bl_req),
    .req_b  (cpu_req),
    .last_b (last_cpu),
    .pick_a (pick_bl),
    .pick_b (pick_cpu)
  );

  assign cpu_prot_wr = cpu_we && (cpu_addr < PROTECT_TOP);

  // Access sequencer: grant in IDLE, issue to RAM, capture and acknowledge.
  // busy is raised with the grant and dropped only in an IDLE cycle with no
  // new grant, so it spans ISSUE, CAPTURE and the ack cycle.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state       <= IDLE;
      gnt         <= GNT_CPU;
      last_cpu    <= 1'b1;
      is_wr       <= 1'b0;
      prot        <= 1'b0;
      ram_en      <= 1'b0;
      ram_wr      <= 1'b0;
      ram_addr    <= '0;
      ram_in      <= '0;
      rdata       <= '0;
      ld_ack      <= 1'b0;
      bl_ack      <= 1'b0;
      cpu_ack     <= 1'b0;
      protect_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ld_ack      <= 1'b0;
      bl_ack      <= 1'b0;
      cpu_ack     <= 1'b0;
      protect_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_req) begin
            ram_addr <= ld_addr;
            ram_in   <= ld_wdata;
            ram_wr   <= ld_we;
            ram_en   <= 1'b1;
            is_wr    <= ld_we;
            prot     <= 1'b0;
            gnt      <= GNT_LD;
            busy     <= 1'b1;
            state    <= ISSUE;
          end else if (pick_bl) begin
            ram_addr <= bl_addr;
            ram_wr   <= 1'b0;
            ram_en   <= 1'b1;
            is_wr    <= 1'b0;
            prot     <= 1'b0;
            gnt      <= GNT_BL;
            last_cpu <= 1'b0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end else if (pick_cpu) begin
            // a protected write runs the full sequence with the RAM disabled
            ram_addr <= cpu_addr;
            ram_in   <= cpu_wdata;
            ram_wr   <= cpu_we && !cpu_prot_wr;
            ram_en   <= !cpu_prot_wr;
            is_wr    <= cpu_we;
            prot     <= cpu_prot_wr;
            gnt      <= GNT_CPU;
            last_cpu <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end else begin
            ram_en   <= 1'b0;
            busy     <= 1'b0;
          end
        end
        ISSUE: begin
          ram_wr <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          if (!is_wr) rdata <= ram_out;
          ld_ack      <= (gnt == GNT_LD);
          bl_ack      <= (gnt == GNT_BL);
          cpu_ack     <= (gnt == GNT_CPU);
          protect_err <= prot;
          ram_en      <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          ram_en <= 1'b0;
          ram_wr <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_ram_arbiter.sv
// Self-checking bench for chip8_ram_arbiter: a behavioural RAM, a
// transaction-level reference model (byte array + priority/round-robin
// rules) and directed plus randomized request patterns.
module tb_chip8_ram_arbiter;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [7:0]  ld_wdata = '0;
  logic        ld_ack;
  logic        bl_req = 1'b0;
  logic [11:0] bl_addr = '0;
  logic        bl_ack;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  rdata;
  logic        ram_en, ram_wr;
  logic [11:0] ram_addr;
  logic [7:0]  ram_in;
  logic [7:0]  ram_out = '0;
  logic        protect_err, busy;

  int tests = 0;
  int fails = 0;

  chip8_ram_arbiter dut (
    .clk(clk), .res_n(res_n),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .bl_req(bl_req), .bl_addr(bl_addr), .bl_ack(bl_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .rdata(rdata), .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_in(ram_in),
    .ram_out(ram_out), .protect_err(protect_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural single-port RAM with synchronous read, plus strobe counters
  logic [7:0] mem [0:4095];
  logic       ram_init = 1'b1;
  int         wr_strobes = 0;
  int         en_edges = 0;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i * 7 + 3);
    end else begin
      if (ram_wr) wr_strobes <= wr_strobes + 1;
      if (ram_en) begin
        en_edges <= en_edges + 1;
        if (ram_wr) mem[ram_addr] <= ram_in;
        ram_out <= mem[ram_addr];
      end
    end
  end

  // reference model state
  logic [7:0]  ref_mem [0:4095];
  logic        last_cpu_m = 1'b1;
  logic [7:0]  exp_rdata = '0;
  logic [2:0]  exp_oh = '0;
  logic        exp_perr = 1'b0;
  int          exp_wr = 0;
  int          exp_en = 0;
  logic        exp_chk = 1'b0;
  logic [11:0] chk_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // winner: 0 loader, 1 blitter, 2 CPU; applies the access to the model
  task automatic model_access(input int w);
    logic        we;
    logic [11:0] a;
    logic [7:0]  d;
    logic        drop;
    we = 1'b0; a = '0; d = '0; drop = 1'b0;
    case (w)
      0: begin we = ld_we; a = ld_addr; d = ld_wdata; exp_oh = 3'b100; end
      1: begin we = 1'b0; a = bl_addr; exp_oh = 3'b010; last_cpu_m = 1'b0; end
      default: begin
        we = cpu_we; a = cpu_addr; d = cpu_wdata; exp_oh = 3'b001; last_cpu_m = 1'b1;
        drop = cpu_we && (int'(cpu_addr) < 'h180);
      end
    endcase
    exp_perr = drop;
    exp_chk  = we;
    chk_addr = a;
    if (!drop) exp_en += 2;
    if (we) begin
      if (!drop) begin
        ref_mem[a] = d;
        exp_wr++;
      end
    end else begin
      exp_rdata = ref_mem[a];
    end
  endtask

  function automatic int predict(input logic l, input logic b, input logic c);
    if (l) return 0;
    if (b && c) return last_cpu_m ? 1 : 2;
    if (b) return 1;
    return 2;
  endfunction

  task automatic wait_ack(output int n, output int bn);
    n = 0; bn = 0;
    do begin
      tick();
      n++;
      if (busy) bn++;
    end while (!(ld_ack || bl_ack || cpu_ack) && n < 8);
  endtask

  task automatic post_check(input int n, input int bn, input int exp_n, input int exp_bn);
    check("ack_latency", n, exp_n);
    check("busy_cycles", bn, exp_bn);
    check("ack_port", {29'd0, ld_ack, bl_ack, cpu_ack}, {29'd0, exp_oh});
    check("rdata", rdata, exp_rdata);
    check("protect_err", protect_err, exp_perr);
    check("wr_strobes", wr_strobes, exp_wr);
    check("en_edges", en_edges, exp_en);
    if (exp_chk) check("mem_content", mem[chk_addr], ref_mem[chk_addr]);
  endtask

  // raise the selected requests together and serve until all have been acked
  task automatic serve(input logic l, input logic b, input logic c);
    logic pl, pb, pc;
    int   w, n, bn;
    pl = l; pb = b; pc = c;
    ld_req = l; bl_req = b; cpu_req = c;
    while (pl || pb || pc) begin
      w = predict(pl, pb, pc);
      model_access(w);
      wait_ack(n, bn);
      post_check(n, bn, 3, 3);
      case (w)
        0: begin pl = 1'b0; ld_req = 1'b0; end
        1: begin pb = 1'b0; bl_req = 1'b0; end
        default: begin pc = 1'b0; cpu_req = 1'b0; end
      endcase
    end
  endtask

  function automatic logic [11:0] rand_addr();
    logic [11:0] pool [0:5];
    pool = '{12'h17E, 12'h17F, 12'h180, 12'h181, 12'h200, 12'h000};
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 5)];
    return 12'($urandom_range(0, 4095));
  endfunction

  initial begin
    int n, bn;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 7 + 3);
    repeat (3) @(posedge clk);
    #1;
    ram_init = 1'b0;

    check("rst_ram_en", ram_en, 1'b0);
    check("rst_acks", {ld_ack, bl_ack, cpu_ack}, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_ram_addr", ram_addr, 12'h000);
    res_n = 1'b1;
    tick();

    // CPU write then read back
    cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'h5A;
    serve(1'b0, 1'b0, 1'b1);
    tick();
    check("busy_release", busy, 1'b0);
    cpu_we = 1'b0;
    serve(1'b0, 1'b0, 1'b1);
    check("cpu_read_5a", rdata, 8'h5A);
    check("single_write", wr_strobes, 1);

    // blitter/CPU ties alternate, blitter first after a CPU grant
    bl_addr = 12'h300; cpu_addr = 12'h301; cpu_we = 1'b0;
    serve(1'b0, 1'b1, 1'b1);
    serve(1'b0, 1'b1, 1'b1);

    // loader holds its request and starves the others
    ld_we = 1'b0; ld_addr = 12'h123;
    ld_req = 1'b1; bl_req = 1'b1; cpu_req = 1'b1;
    repeat (3) begin
      model_access(0);
      wait_ack(n, bn);
      post_check(n, bn, 3, 3);
    end
    serve(1'b0, 1'b1, 1'b1);

    // write protection boundary
    cpu_we = 1'b1; cpu_addr = 12'h17F; cpu_wdata = 8'hFF;
    serve(1'b0, 1'b0, 1'b1);
    check("prot_mem_17f", mem[12'h17F], ref_mem[12'h17F]);
    cpu_addr = 12'h180; cpu_wdata = 8'h3C;
    serve(1'b0, 1'b0, 1'b1);
    check("unprot_mem_180", mem[12'h180], 8'h3C);
    ld_we = 1'b1; ld_addr = 12'h000; ld_wdata = 8'hA5;
    serve(1'b1, 1'b0, 1'b0);
    check("ld_mem_000", mem[12'h000], 8'hA5);

    // reset during ISSUE of a CPU read
    cpu_we = 1'b0; cpu_addr = 12'h200; cpu_req = 1'b1;
    tick();
    res_n = 1'b0; cpu_req = 1'b0;
    #1;
    check("midrst_ram_en", ram_en, 1'b0);
    check("midrst_acks", {ld_ack, bl_ack, cpu_ack}, 3'b000);
    check("midrst_busy", busy, 1'b0);
    last_cpu_m = 1'b1; exp_rdata = 8'h00;
    tick();
    tick();
    check("midrst_no_en", en_edges, exp_en);
    res_n = 1'b1;
    tick();
    serve(1'b0, 1'b0, 1'b1);
    check("post_rst_read", rdata, 8'h5A);

    // CPU drops its request right after the grant
    cpu_we = 1'b0; cpu_addr = 12'h301; cpu_req = 1'b1;
    model_access(2);
    tick();
    cpu_req = 1'b0;
    wait_ack(n, bn);
    post_check(n, bn, 2, 2);
    repeat (4) tick();
    check("drop_no_second", en_edges, exp_en);
    check("drop_no_ack", cpu_ack, 1'b0);

    // randomized mixes of requesters and fields
    for (int it = 0; it < 40; it++) begin
      logic [2:0] m;
      m = 3'($urandom_range(1, 7));
      ld_we = 1'($urandom); ld_addr = rand_addr(); ld_wdata = 8'($urandom);
      bl_addr = rand_addr();
      cpu_we = 1'($urandom); cpu_addr = rand_addr(); cpu_wdata = 8'($urandom);
      serve(m[2], m[1], m[0]);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
